// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controllers.
// Holds the state encoding and the default FIFO word width.
package fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] LAUNCH    = 2'b01;
    localparam logic [1:0] WAIT_BUSY = 2'b10;
    localparam logic [1:0] WAIT_DONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = IDLE,
        ST_LAUNCH    = LAUNCH,
        ST_WAIT_BUSY = WAIT_BUSY,
        ST_WAIT_DONE = WAIT_DONE
    } state_t;

endpackage

// File: rtl/fifo_tx_drain_ctrl.sv
// Drains the FIFO into UART_TX one word per frame; strobes appear one cycle after the IDLE decision edge.
// A new pop waits for EN, a non-empty FIFO and an idle UART; a TX that never goes busy is abandoned after BUSY_TIMEOUT cycles.
module fifo_tx_drain_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr_err,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  uart_busy,
    output logic                  fifo_rd_inc,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_data_valid,
    output logic [CNT_WIDTH-1:0]  tx_count,
    output logic                  timeout_err
);

    localparam int              TO_W     = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BUSY_TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_inc;
    logic            launch;
    logic            to_expire;
    logic            frame_done;

    assign to_cnt_inc = to_cnt + TO_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        to_expire  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && !fifo_empty && !uart_busy) begin
                    launch    = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (to_cnt_inc == TO_LIMIT) begin
                    // the popped word is dropped; nothing is counted for it
                    to_expire = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_rd_inc   <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            tx_count      <= '0;
            timeout_err   <= 1'b0;
            to_cnt        <= '0;
        end else begin
            fifo_rd_inc   <= launch;
            tx_data_valid <= launch;
            // only the launch edge loads the word, so it holds for the whole frame
            if (launch) begin
                tx_p_data <= fifo_rd_data;
            end
            if (state == ST_LAUNCH) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT_BUSY && !uart_busy) begin
                to_cnt <= to_cnt_inc;
            end
            if (frame_done) begin
                tx_count <= tx_count + CNT_WIDTH'(1);
            end
            if (to_expire) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_tx_drain_ctrl.sv
// Self-checking bench for fifo_tx_drain_ctrl with a FIFO model, a UART busy model and a launch scoreboard.
// A second instance with a 4-bit frame counter shares all inputs to exercise counter wrap.
module tb_fifo_tx_drain_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int DW = 8;
    localparam int BT = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr_err;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          uart_busy;
    logic          fifo_rd_inc;
    logic          tx_data_valid;
    logic          timeout_err;
    logic [DW-1:0] tx_p_data;
    logic [15:0]   tx_count;
    logic          n_rd_inc;
    logic          n_valid;
    logic          n_err;
    logic [DW-1:0] n_data;
    logic [3:0]    n_count;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    int            pops        = 0;
    int            valid_cnt   = 0;
    int            last_fall   = -100;
    int            frame_len   = 10;
    int            busy_left   = 0;
    bit            busy_never  = 1'b0;
    bit            busy_pend   = 1'b0;
    bit            frame_live  = 1'b0;
    bit            prev_valid  = 1'b0;
    bit            chk_gap     = 1'b0;
    bit            have_last   = 1'b0;
    logic [15:0]   exp_count   = '0;
    logic [DW-1:0] last_data   = '0;

    assign fifo_empty   = (fifo_q.size() == 0);
    assign fifo_rd_data = fifo_empty ? '0 : fifo_q[0];

    fifo_tx_drain_ctrl #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .uart_busy(uart_busy), .fifo_rd_inc(fifo_rd_inc),
        .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid), .tx_count(tx_count),
        .timeout_err(timeout_err)
    );

    fifo_tx_drain_ctrl #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT), .CNT_WIDTH(4)) dut_n (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .uart_busy(uart_busy), .fifo_rd_inc(n_rd_inc),
        .tx_p_data(n_data), .tx_data_valid(n_valid), .tx_count(n_count),
        .timeout_err(n_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: sample outputs at the falling edge, score launches, then advance the FIFO and busy models.
    task automatic tick();
        logic          busy_seen;
        logic [DW-1:0] e;
        @(negedge clk);
        cyc++;
        busy_seen = uart_busy;
        if (uart_busy) begin
            busy_left--;
            if (busy_left <= 0) begin
                uart_busy = 1'b0;
                last_fall = cyc;
                if (frame_live) begin
                    exp_count  = exp_count + 16'd1;
                    frame_live = 1'b0;
                end
            end
        end else if (busy_pend) begin
            uart_busy = 1'b1;
            busy_left = frame_len;
            busy_pend = 1'b0;
        end
        if (rst) begin
            vectors++;
            if (fifo_rd_inc !== tx_data_valid) begin
                miscompares++;
                $display("FAIL strobe_pair: rd_inc=%b valid=%b, want equal", fifo_rd_inc, tx_data_valid);
            end
            if (tx_data_valid === 1'b1) begin
                vectors++;
                if (prev_valid) begin
                    miscompares++;
                    $display("FAIL strobe_width: valid high 2 cycles at cyc %0d, want 1", cyc);
                end
                vectors++;
                if (busy_seen) begin
                    miscompares++;
                    $display("FAIL launch_busy: launch with uart_busy=1 at cyc %0d, want 0", cyc);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_launch: data %h at cyc %0d, want none", tx_p_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_p_data !== e) begin
                        miscompares++;
                        $display("FAIL launch_data: got %h want %h", tx_p_data, e);
                    end
                    last_data = e;
                    have_last = 1'b1;
                end
                if (chk_gap) begin
                    vectors++;
                    if (cyc - last_fall != 2) begin
                        miscompares++;
                        $display("FAIL turnaround: got %0d want 2", cyc - last_fall);
                    end
                end
                valid_cnt++;
                frame_live = 1'b1;
                if (!busy_never) busy_pend = 1'b1;
            end else if (busy_seen && have_last) begin
                vectors++;
                if (tx_p_data !== last_data) begin
                    miscompares++;
                    $display("FAIL data_stable: got %h want %h", tx_p_data, last_data);
                end
            end
            if (fifo_rd_inc === 1'b1) begin
                pops++;
                if (fifo_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_empty: pop with empty FIFO at cyc %0d, want none", cyc);
                end else begin
                    void'(fifo_q.pop_front());
                end
            end
        end
        prev_valid = tx_data_valid;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (!(fifo_q.size() == 0 && !uart_busy && !busy_pend && dut.state == ST_IDLE) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_drain: not idle after %0d cycles, want idle", nm, n);
        end
        tick();
        tick();
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int v0 = valid_cnt;
        int n  = 0;
        while (valid_cnt == v0 && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (valid_cnt == v0) begin
            miscompares++;
            $display("FAIL %s_launch: no launch within %0d cycles, want one", nm, budget);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({fifo_rd_inc, tx_data_valid, timeout_err, tx_p_data, tx_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: inc=%b vld=%b err=%b data=%h cnt=%0d, want all 0",
                     fifo_rd_inc, tx_data_valid, timeout_err, tx_p_data, tx_count);
        end
        vectors++;
        if (dut.state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int v0 = valid_cnt;
        int p0 = pops;
        frame_len = 10;
        push_word(8'hA5);
        en = 1'b1;
        wait_idle(100, "single");
        vectors++;
        if (valid_cnt - v0 != 1 || pops - p0 != 1) begin
            miscompares++;
            $display("FAIL single_strobes: valids=%0d pops=%0d want 1/1", valid_cnt - v0, pops - p0);
        end
        vectors++;
        if (tx_count !== 16'd1 || exp_count !== 16'd1) begin
            miscompares++;
            $display("FAIL single_count: got %0d model %0d want 1", tx_count, exp_count);
        end
        vectors++;
        if (tx_p_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_hold: got %h want a5", tx_p_data);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        int p0 = pops;
        frame_len = 6;
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        wait_valid(20, "burst");
        chk_gap = 1'b1;
        wait_idle(200, "burst");
        chk_gap = 1'b0;
        vectors++;
        if (valid_cnt - v0 != 3 || pops - p0 != 3) begin
            miscompares++;
            $display("FAIL burst_strobes: valids=%0d pops=%0d want 3/3", valid_cnt - v0, pops - p0);
        end
        vectors++;
        if (tx_count !== exp_count || tx_count !== 16'd4) begin
            miscompares++;
            $display("FAIL burst_count: got %0d model %0d want 4", tx_count, exp_count);
        end
        vectors++;
        if (fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_empty: got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] c0 = exp_count;
        busy_never = 1'b1;
        push_word(8'h3C);
        wait_valid(20, "timeout");
        for (int k = 1; k <= BT + 1; k++) begin
            tick();
            vectors++;
            if (timeout_err !== (k == BT + 1)) begin
                miscompares++;
                $display("FAIL timeout_err_k%0d: got %b want %b", k, timeout_err, k == BT + 1);
            end
        end
        vectors++;
        if (dut.state !== ST_IDLE || tx_count !== c0) begin
            miscompares++;
            $display("FAIL timeout_abort: state=%0d cnt=%0d want IDLE/%0d", dut.state, tx_count, c0);
        end
        busy_never = 1'b0;
        push_word(8'h5C);
        wait_idle(100, "after_timeout");
        vectors++;
        if (tx_count !== c0 + 16'd1 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_next: cnt=%0d err=%b want %0d/1", tx_count, timeout_err, c0 + 16'd1);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_err: got %b want 0", timeout_err);
        end
    endtask

    task automatic test_gating();
        int p0;
        en = 1'b0;
        push_word(8'h11);
        for (int k = 0; k < 50; k++) begin
            tick();
            vectors++;
            if (fifo_rd_inc !== 1'b0) begin
                miscompares++;
                $display("FAIL en_gate: pop with en=0 at cyc %0d, want none", cyc);
            end
        end
        en = 1'b1;
        wait_idle(100, "en_resume");
        push_word(8'h22);
        push_word(8'h33);
        p0 = pops;
        for (int k = 0; k < 50 && dut.state != ST_WAIT_DONE; k++) tick();
        en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            vectors++;
            if (fifo_rd_inc !== 1'b0) begin
                miscompares++;
                $display("FAIL en_drop: pop after en dropped at cyc %0d, want none", cyc);
            end
        end
        vectors++;
        if (pops - p0 != 1 || fifo_q.size() != 1 || tx_count !== exp_count || tx_count !== 16'd7) begin
            miscompares++;
            $display("FAIL en_drop_frame: pops=%0d left=%0d cnt=%0d want 1/1/7", pops - p0, fifo_q.size(), tx_count);
        end
        en = 1'b1;
        wait_idle(100, "en_drain");
    endtask

    task automatic test_wrap();
        int m = 15 - int'(exp_count[3:0]);
        frame_len = 2;
        for (int k = 0; k < m; k++) push_word(DW'(8'h40 + k));
        wait_idle(400, "wrap_fill");
        vectors++;
        if (n_count !== 4'd15 || tx_count !== exp_count) begin
            miscompares++;
            $display("FAIL wrap_pre: narrow=%0d wide=%0d want 15/%0d", n_count, tx_count, exp_count);
        end
        push_word(8'hEE);
        wait_idle(50, "wrap_last");
        vectors++;
        if (n_count !== 4'd0 || tx_count !== exp_count || tx_count !== 16'd16) begin
            miscompares++;
            $display("FAIL wrap_post: narrow=%0d wide=%0d want 0/16", n_count, tx_count);
        end
    endtask

    task automatic test_clr_collision();
        busy_never = 1'b1;
        push_word(8'h99);
        wait_valid(20, "collide");
        for (int k = 0; k < BT; k++) tick();
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_pre: got %b want 0", timeout_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        vectors++;
        if (timeout_err !== 1'b1 || n_err !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_set_wins: got %b/%b want 1/1", timeout_err, n_err);
        end
        busy_never = 1'b0;
        wait_idle(50, "collide");
    endtask

    task automatic test_reset_mid_frame();
        frame_len = 10;
        push_word(8'h5A);
        for (int k = 0; k < 30 && dut.state != ST_WAIT_DONE; k++) tick();
        tick();
        vectors++;
        if (dut.state !== ST_WAIT_DONE) begin
            miscompares++;
            $display("FAIL rst_mid_setup: state %0d want %0d", dut.state, ST_WAIT_DONE);
        end
        rst = 1'b0;
        #1;
        exp_count  = '0;
        frame_live = 1'b0;
        have_last  = 1'b0;
        vectors++;
        if ({fifo_rd_inc, tx_data_valid, timeout_err, tx_p_data, tx_count} !== '0 ||
            {n_rd_inc, n_valid, n_err, n_data, n_count} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: err=%b data=%h cnt=%0d ncnt=%0d want all 0",
                     timeout_err, tx_p_data, tx_count, n_count);
        end
        vectors++;
        if (dut.state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL rst_mid_state: got %0d want %0d", dut.state, ST_IDLE);
        end
        push_word(8'h77);
        tick();
        rst = 1'b1;
        wait_idle(100, "post_reset");
        vectors++;
        if (tx_count !== 16'd1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset: cnt=%0d pending=%0d want 1/0", tx_count, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        clr_err   = 1'b0;
        uart_busy = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_gating();
        test_wrap();
        test_clr_collision();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
